// File: rtl/mem_access_unit.sv
// Multi-cycle load/store stage: drives a valid/ready data-memory port, aligns store lanes, extends load data.
// Optional MISALIGN_CHECK_EN: misaligned halfword/word accesses skip memory and raise ale.
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic [5:0]        op,
    input  logic [ADDR_W-1:0] addr,
    input  logic [31:0]       wdata,
    input  logic [4:0]        rd,
    output logic              stall,
    output logic              done,
    output logic              wb_en,
    output logic [4:0]        wb_rd,
    output logic [31:0]       wb_data,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [3:0]        mem_wstrb,
    output logic [31:0]       mem_wdata,
    input  logic              mem_ready,
    input  logic              mem_rvalid,
    input  logic [31:0]       mem_rdata
`ifdef MISALIGN_CHECK_EN
    ,
    output logic              ale
`endif
);

    localparam logic [5:0] OP_STW  = 6'h16;
    localparam logic [5:0] OP_STH  = 6'h17;
    localparam logic [5:0] OP_STB  = 6'h18;
    localparam logic [5:0] OP_LDW  = 6'h19;
    localparam logic [5:0] OP_LDH  = 6'h1a;
    localparam logic [5:0] OP_LDB  = 6'h1b;
    localparam logic [5:0] OP_LDHU = 6'h1c;
    localparam logic [5:0] OP_LDBU = 6'h1d;

    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

    function automatic logic is_mem(input logic [5:0] f_op);
        return (f_op >= OP_STW) && (f_op <= OP_LDBU);
    endfunction

    function automatic logic is_load(input logic [5:0] f_op);
        return (f_op >= OP_LDW) && (f_op <= OP_LDBU);
    endfunction

    function automatic logic [3:0] store_strb(input logic [5:0] f_op, input logic [1:0] f_off);
        logic [3:0] strb;
        case (f_op)
            OP_STB:  strb = 4'b0001 << f_off;
            OP_STH:  strb = f_off[1] ? 4'b1100 : 4'b0011;
            default: strb = 4'b1111;
        endcase
        return strb;
    endfunction

    function automatic logic [31:0] store_data(input logic [5:0] f_op, input logic [31:0] f_w);
        logic [31:0] d;
        case (f_op)
            OP_STB:  d = {4{f_w[7:0]}};
            OP_STH:  d = {2{f_w[15:0]}};
            default: d = f_w;
        endcase
        return d;
    endfunction

    function automatic logic [31:0] load_extract(input logic [5:0] f_op, input logic [1:0] f_off,
                                                 input logic [31:0] f_rdata);
        logic [31:0]        shifted;
        logic [15:0]        half;
        logic signed [7:0]  b_s;
        logic signed [15:0] h_s;
        logic [31:0]        res;
        shifted = f_rdata >> {f_off, 3'b000};
        half    = f_off[1] ? f_rdata[31:16] : f_rdata[15:0];
        b_s     = signed'(shifted[7:0]);
        h_s     = signed'(half);
        case (f_op)
            OP_LDB:  res = 32'(b_s);
            OP_LDBU: res = {24'b0, shifted[7:0]};
            OP_LDH:  res = 32'(h_s);
            OP_LDHU: res = {16'b0, half};
            default: res = f_rdata;
        endcase
        return res;
    endfunction

`ifdef MISALIGN_CHECK_EN
    function automatic logic misaligned(input logic [5:0] f_op, input logic [1:0] f_off);
        logic m;
        case (f_op)
            OP_STH, OP_LDH, OP_LDHU: m = f_off[0];
            OP_STW, OP_LDW:          m = (f_off != 2'b00);
            default:                 m = 1'b0;
        endcase
        return m;
    endfunction
`endif

    state_t              state_q, state_d;
    logic [5:0]          op_q, op_d;
    logic [1:0]          off_q, off_d;
    logic                done_q, done_d;
    logic                wb_en_q, wb_en_d;
    logic [4:0]          wb_rd_q, wb_rd_d;
    logic [31:0]         wb_data_q, wb_data_d;
    logic                mem_req_q, mem_req_d;
    logic                mem_we_q, mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [3:0]          mem_wstrb_q, mem_wstrb_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
`ifdef MISALIGN_CHECK_EN
    logic                ale_q, ale_d;
`endif
    logic                accept;

    assign accept = valid_in && is_mem(op);

    // stall is gated by rst_n so a reset mid-access releases upstream immediately
    assign stall = rst_n && (((state_q == IDLE) && accept) || (state_q == REQ) || (state_q == WAIT));

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        off_d       = off_q;
        done_d      = done_q;
        wb_en_d     = wb_en_q;
        wb_rd_d     = wb_rd_q;
        wb_data_d   = wb_data_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
`ifdef MISALIGN_CHECK_EN
        ale_d       = ale_q;
`endif
        case (state_q)
            IDLE: begin
                if (accept) begin
                    op_d    = op;
                    off_d   = addr[1:0];
                    wb_rd_d = rd;
`ifdef MISALIGN_CHECK_EN
                    if (misaligned(op, addr[1:0])) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        ale_d   = 1'b1;
                    end else
`endif
                    begin
                        state_d     = REQ;
                        mem_req_d   = 1'b1;
                        mem_we_d    = !is_load(op);
                        mem_addr_d  = {addr[ADDR_W-1:2], 2'b00};
                        mem_wstrb_d = is_load(op) ? 4'b0000 : store_strb(op, addr[1:0]);
                        mem_wdata_d = is_load(op) ? 32'h0 : store_data(op, wdata);
                    end
                end
            end
            REQ: begin
                if (mem_ready) begin
                    mem_req_d = 1'b0;
                    if (mem_we_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_rvalid) begin
                    wb_data_d = load_extract(op_q, off_q, mem_rdata);
                    state_d   = DONE;
                    done_d    = 1'b1;
                    wb_en_d   = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
                done_d  = 1'b0;
                wb_en_d = 1'b0;
`ifdef MISALIGN_CHECK_EN
                ale_d   = 1'b0;
`endif
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            op_q        <= 6'h0;
            off_q       <= 2'b00;
            done_q      <= 1'b0;
            wb_en_q     <= 1'b0;
            wb_rd_q     <= 5'd0;
            wb_data_q   <= 32'h0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'h0;
`ifdef MISALIGN_CHECK_EN
            ale_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            off_q       <= off_d;
            done_q      <= done_d;
            wb_en_q     <= wb_en_d;
            wb_rd_q     <= wb_rd_d;
            wb_data_q   <= wb_data_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
`ifdef MISALIGN_CHECK_EN
            ale_q       <= ale_d;
`endif
        end
    end

    assign done      = done_q;
    assign wb_en     = wb_en_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
`ifdef MISALIGN_CHECK_EN
    assign ale       = ale_q;
`endif

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: vector table plus scoreboard on the done pulse.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [5:0]  op;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [4:0]  rd;
    logic        stall;
    logic        done;
    logic        wb_en;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [3:0]  mem_wstrb;
    logic [31:0] mem_wdata;
    logic        mem_ready;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;
`ifdef MISALIGN_CHECK_EN
    logic        ale;
`endif

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst_n(rst_n), .valid_in(valid_in), .op(op), .addr(addr),
        .wdata(wdata), .rd(rd), .stall(stall), .done(done), .wb_en(wb_en),
        .wb_rd(wb_rd), .wb_data(wb_data), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
`ifdef MISALIGN_CHECK_EN
        , .ale(ale)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]  op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rdata;
        int          rdly;
        int          vdly;
        logic [3:0]  strb;
        logic [31:0] mwdata;
        logic [31:0] wbdata;
    } vec_t;

    typedef struct packed {
        logic        en;
        logic [4:0]  rd;
        logic [31:0] data;
    } exp_t;

    vec_t vecs[12];
    exp_t sbq[$];
    exp_t mon_e;
    int   checks = 0;
    int   errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (rst_n && done) begin
            if (sbq.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected_done actual=1 expected=0 t=%0t", $time);
            end else begin
                mon_e = sbq.pop_front();
                chk1("sb_wb_en", wb_en, mon_e.en);
                if (mon_e.en) begin
                    chk("sb_wb_rd", {27'b0, wb_rd}, {27'b0, mon_e.rd});
                    chk("sb_wb_data", wb_data, mon_e.data);
                end
            end
        end
    end

    task automatic run_vec(input vec_t v);
        logic ld;
        ld = (v.op >= 6'h19);
        valid_in = 1'b1; op = v.op; addr = v.addr; wdata = v.wdata; rd = v.rd;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h5A5A_5A5A;
        #1 chk1("stall_accept", stall, 1'b1);
        sbq.push_back('{ld, v.rd, v.wbdata});
        tick();
        valid_in = 1'b0; op = 6'h00; addr = 32'hFFFF_FFFF; wdata = 32'h0;
        for (int i = 0; i <= v.rdly; i++) begin
            if (i == v.rdly) mem_ready = 1'b1;
            #1;
            chk1("req_mem_req", mem_req, 1'b1);
            chk1("req_mem_we", mem_we, ~ld);
            chk("req_mem_addr", mem_addr, {v.addr[31:2], 2'b00});
            if (!ld) begin
                chk("req_wstrb", {28'b0, mem_wstrb}, {28'b0, v.strb});
                chk("req_wdata", mem_wdata, v.mwdata);
            end
            chk1("req_stall", stall, 1'b1);
            chk1("req_done", done, 1'b0);
            tick();
        end
        mem_ready = 1'b0;
        if (ld) begin
            for (int i = 0; i <= v.vdly; i++) begin
                if (i == v.vdly) begin
                    mem_rvalid = 1'b1;
                    mem_rdata = v.rdata;
                end
                #1;
                chk1("wait_mem_req", mem_req, 1'b0);
                chk1("wait_stall", stall, 1'b1);
                chk1("wait_done", done, 1'b0);
                tick();
            end
            mem_rvalid = 1'b0;
            mem_rdata = 32'h5A5A_5A5A;
        end
        chk1("done_pulse", done, 1'b1);
        chk1("done_wb_en", wb_en, ld);
        chk1("done_stall", stall, 1'b0);
        chk1("done_mem_req", mem_req, 1'b0);
        if (ld) chk("done_wb_data", wb_data, v.wbdata);
`ifdef MISALIGN_CHECK_EN
        chk1("done_ale", ale, 1'b0);
`endif
        tick();
        chk1("idle_done", done, 1'b0);
        chk1("idle_wb_en", wb_en, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0]  = '{6'h18, 32'h0000_1003, 32'h0000_00AB, 5'd1,  32'h0,         0, 0, 4'b1000, 32'hABAB_ABAB, 32'h0};
        vecs[1]  = '{6'h1b, 32'h0000_2002, 32'h0,         5'd5,  32'h12F4_5678, 0, 0, 4'b0000, 32'h0,         32'hFFFF_FFF4};
        vecs[2]  = '{6'h1d, 32'h0000_2002, 32'h0,         5'd6,  32'h12F4_5678, 0, 0, 4'b0000, 32'h0,         32'h0000_00F4};
        vecs[3]  = '{6'h1a, 32'h0000_2002, 32'h0,         5'd7,  32'h12F4_5678, 3, 2, 4'b0000, 32'h0,         32'h0000_12F4};
        vecs[4]  = '{6'h17, 32'h0000_1006, 32'h1234_CAFE, 5'd2,  32'h0,         0, 0, 4'b1100, 32'hCAFE_CAFE, 32'h0};
        vecs[5]  = '{6'h16, 32'h0000_1008, 32'hDEAD_BEEF, 5'd3,  32'h0,         2, 0, 4'b1111, 32'hDEAD_BEEF, 32'h0};
        vecs[6]  = '{6'h1c, 32'h0000_2000, 32'h0,         5'd8,  32'h1234_8001, 0, 0, 4'b0000, 32'h0,         32'h0000_8001};
        vecs[7]  = '{6'h1a, 32'h0000_2000, 32'h0,         5'd9,  32'h1234_8001, 0, 1, 4'b0000, 32'h0,         32'hFFFF_8001};
        vecs[8]  = '{6'h19, 32'h0000_200C, 32'h0,         5'd10, 32'hCAFE_F00D, 1, 1, 4'b0000, 32'h0,         32'hCAFE_F00D};
        vecs[9]  = '{6'h1b, 32'h0000_2001, 32'h0,         5'd11, 32'h0000_8000, 0, 0, 4'b0000, 32'h0,         32'hFFFF_FF80};
        vecs[10] = '{6'h18, 32'h0000_1001, 32'h1234_5677, 5'd4,  32'h0,         0, 0, 4'b0010, 32'h7777_7777, 32'h0};
        vecs[11] = '{6'h1d, 32'h0000_2003, 32'h0,         5'd31, 32'hA500_0000, 0, 0, 4'b0000, 32'h0,         32'h0000_00A5};

        rst_n = 1'b0; valid_in = 1'b0; op = 6'h0; addr = 32'h0; wdata = 32'h0; rd = 5'd0;
        mem_ready = 1'b0; mem_rvalid = 1'b0; mem_rdata = 32'h0;
        #3;
        chk1("rst_mem_req", mem_req, 1'b0);
        chk1("rst_done", done, 1'b0);
        chk1("rst_wb_en", wb_en, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk("rst_wb_data", wb_data, 32'h0);
        chk("rst_mem_addr", mem_addr, 32'h0);
        chk("rst_wstrb", {28'b0, mem_wstrb}, 32'h0);
        chk("rst_wdata", mem_wdata, 32'h0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 12; i++) run_vec(vecs[i]);

        // non-memory ops: no stall, no request, no completion
        valid_in = 1'b1;
        for (int i = 0; i < 4; i++) begin
            case (i)
                0: op = 6'h00;
                1: op = 6'h15;
                2: op = 6'h1e;
                default: op = 6'h3f;
            endcase
            addr = 32'h0000_1000;
            #1 chk1("nonmem_stall", stall, 1'b0);
            tick();
            chk1("nonmem_mem_req", mem_req, 1'b0);
            chk1("nonmem_done", done, 1'b0);
        end
        valid_in = 1'b0;
        tick();

        // reset while in REQ
        valid_in = 1'b1; op = 6'h19; addr = 32'h0000_4000; rd = 5'd12; mem_ready = 1'b0;
        tick();
        valid_in = 1'b0;
        chk1("rstreq_pre_req", mem_req, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rstreq_mem_req", mem_req, 1'b0);
        chk1("rstreq_stall", stall, 1'b0);
        chk("rstreq_mem_addr", mem_addr, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();

        // reset while in WAIT, then a stale rvalid
        valid_in = 1'b1; op = 6'h19; addr = 32'h0000_4004; rd = 5'd13; mem_ready = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        mem_ready = 1'b0;
        chk1("rstwait_pre_stall", stall, 1'b1);
        #2 rst_n = 1'b0;
        #1;
        chk1("rstwait_stall", stall, 1'b0);
        chk1("rstwait_done", done, 1'b0);
        chk1("rstwait_mem_req", mem_req, 1'b0);
        tick();
        rst_n = 1'b1;
        mem_rvalid = 1'b1; mem_rdata = 32'h1111_2222;
        tick();
        mem_rvalid = 1'b0;
        chk1("stale_wb_en", wb_en, 1'b0);
        chk1("stale_done", done, 1'b0);
        chk("stale_wb_data", wb_data, 32'h0);
        tick();
        chk1("stale_wb_en2", wb_en, 1'b0);
        chk1("stale_done2", done, 1'b0);

`ifdef MISALIGN_CHECK_EN
        // misaligned word load and halfword store bypass memory
        for (int i = 0; i < 2; i++) begin
            valid_in = 1'b1;
            op = (i == 0) ? 6'h19 : 6'h17;
            addr = 32'h0000_3001; rd = 5'd14; mem_ready = 1'b1;
            sbq.push_back('{1'b0, 5'd14, 32'h0});
            tick();
            valid_in = 1'b0;
            chk1("ale_mem_req", mem_req, 1'b0);
            chk1("ale_done", done, 1'b1);
            chk1("ale_flag", ale, 1'b1);
            chk1("ale_wb_en", wb_en, 1'b0);
            tick();
            chk1("ale_clear", ale, 1'b0);
            chk1("ale_no_req", mem_req, 1'b0);
        end
        mem_ready = 1'b0;
`endif

        tick();
        tick();
        chk("sb_drained", sbq.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
